instruction_fetcher: RTL
========================

# instruction_fetcher

Front-end fetch unit: the producer side of the decoder's instruction interface. Fetches 16/32-bit RV32IC instructions from the memory controller one at a time, predicts branches with a bimodal table, follows JAL/C.J/C.JAL statically, and presents one instruction at a time to the decoder. It honours the decoder's combinational stall, the decoder's JALR redirect, and the ROB's mispredict flush.

## Interface
- BHT_BITS, 6: log2 of predictor entries; index = pc[BHT_BITS:1].
- RESET_PC, 32'h0: fetch address after reset.

- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  when low, all state frozen; outputs held.
- mem_req_valid  out  1  fetch request; held until mem_resp_valid.
- mem_req_addr  out  32  halfword-aligned fetch address.
- mem_resp_valid  in  1  one-cycle pulse; mem_resp_data valid.
- mem_resp_data  in  32  32 bits starting at mem_req_addr.
- dec_ins_ready  out  1  instruction presented to decoder.
- dec_ins  out  32  instruction; compressed → {16'b0, half}.
- dec_pc  out  32  {pc[31:1], predicted_taken}.
- dec_predict_nxt_pc  out  32  predicted next fetch address.
- dec_stall  in  1  decoder cannot accept (combinational).
- dec_clear  in  1  JALR redirect pulse.
- dec_new_addr  in  32  JALR target.
- rob_clear  in  1  mispredict flush pulse.
- rob_new_pc  in  32  correct fetch address.
- br_update_valid  in  1  committed branch outcome.
- br_update_pc  in  32  committed branch pc.
- br_update_taken  in  1  actual direction.

## Operation
- States: FETCH (request outstanding), PRESENT (dec_ins_ready=1), WAIT_JALR (JALR issued; waiting for dec_clear), DISCARD (stale request outstanding after a redirect).
- Reset (rst_in=0, async): state=FETCH, fetch_pc=RESET_PC, mem_req_valid=0 for one cycle then 1, dec_ins_ready=0, dec_ins=0, dec_pc=0, dec_predict_nxt_pc=0. Every BHT counter = 2'b01.
- FETCH: mem_req_valid=1, mem_req_addr=fetch_pc. On mem_resp_valid, decode the word and register the outputs. Go to PRESENT.
- Decode of the word w:
  - compressed iff w[1:0]!=2'b11; len=2, else len=4.
  - JAL (opcode 1101111): target=pc+immJ; taken.
  - C.J/C.JAL (w[1:0]=01, w[15:13]=101/001): target=pc+sext({w[12],w[8],w[10:9],w[6],w[7],w[2],w[11],w[5:3],0}); taken.
  - B (opcode 1100011): target=pc+immB.
  - C.BEQZ/C.BNEZ (w[1:0]=01, w[15:13]=11x): target=pc+sext({w[12],w[6:5],w[2],w[11:10],w[4:3],0}).
  - Branch direction: taken iff BHT[pc][1]=1.
  - JALR (opcode 1100111, or w[1:0]=10, w[15:13]=100, w[6:2]=0, w[11:7]!=0): flagged jalr.
  - Otherwise: next = pc+len, not taken.
  - dec_predict_nxt_pc = taken ? target : pc+len.
  - dec_pc[0] = taken.
- PRESENT: outputs are held stable while dec_stall=1. Acceptance happens in a cycle with dec_ins_ready=1 and dec_stall=0. On acceptance:
  - if jalr: go to WAIT_JALR.
  - else: fetch_pc=dec_predict_nxt_pc, go to FETCH.
  - In both cases dec_ins_ready=0 next cycle.
- WAIT_JALR: no requests. On dec_clear: fetch_pc=dec_new_addr, go to FETCH.
- rob_clear (highest priority after reset, any state): fetch_pc=rob_new_pc, dec_ins_ready=0. If a request is outstanding (FETCH/DISCARD), go to DISCARD; else go to FETCH.
- dec_clear outside WAIT_JALR: same handling as rob_clear but with dec_new_addr. If dec_clear and rob_clear arrive together, rob_clear wins.
- DISCARD: keep mem_req_valid=1 at the old address. Drop the response, then go to FETCH with the new fetch_pc.
- BHT update on br_update_valid: 2-bit saturating counter at br_update_pc[BHT_BITS:1], +1 if taken, −1 if not, saturating at 00/11. A lookup and an update to the same index in the same cycle: the lookup sees the old value.
- All pc arithmetic is 32-bit modulo 2^32; immediates are sign-extended to 32 bits.

## Timing
- Request to present: mem_resp_valid in cycle t → dec_ins_ready=1 from t+1.
- Acceptance in cycle a:
  - dec_ins_ready=0 at a+1.
  - mem_req_valid=1 with the new address at a+1.
  - The same address is never presented twice in a row unless fetched again after a redirect.
- Redirect pulse in cycle r → fetch_pc updated at r+1, mem_req_valid at r+1 (from FETCH/WAIT_JALR/PRESENT).
- rdy_in=0: no state change, and mem_resp_valid is ignored. The memory controller also pauses, so no responses are lost.

## Test plan
- Reset, straight-line code: words at 0x0 (addi), 0x4 (c.addi 0x0505) → dec_pc=0x0, next 0x4; then dec_pc=0x4, dec_ins=0x00000505, next 0x6.
- Stall hold: dec_stall=1 for 5 cycles while presenting 0x8 → outputs unchanged, no mem_req_valid; accepted on release → request 0xC next cycle.
- JAL at 0x10 with imm=+0x40 → dec_predict_nxt_pc=0x50, dec_pc=0x11, next request 0x50.
- Branch learning at 0x20 (imm +0x10): initially predicted not-taken (next 0x24). After two br_update taken → predicted taken, dec_pc=0x21, next 0x30.
- JALR at 0x40 → WAIT_JALR, no requests; dec_clear with 0x100 → request 0x100 next cycle.
- rob_clear to 0x200 while a request for 0x60 is outstanding → the 0x60 response is dropped, never presented; next request 0x200. Async reset asserted mid-fetch → dec_ins_ready=0 immediately, restart at RESET_PC.

Source files
------------

// File: rtl/instruction_fetcher_if.sv
// Fetch-side bus bundle: memory request/response channel plus the decoder instruction channel.
// The fetcher drives it through the master modport; memory and decoder sit on the slave side.
interface instruction_fetcher_if;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        dec_ins_ready;
  logic [31:0] dec_ins;
  logic [31:0] dec_pc;
  logic [31:0] dec_predict_nxt_pc;
  logic        dec_stall;
  logic        dec_clear;
  logic [31:0] dec_new_addr;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_resp_valid, mem_resp_data,
    output dec_ins_ready, dec_ins, dec_pc, dec_predict_nxt_pc,
    input  dec_stall, dec_clear, dec_new_addr
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_resp_valid, mem_resp_data,
    input  dec_ins_ready, dec_ins, dec_pc, dec_predict_nxt_pc,
    output dec_stall, dec_clear, dec_new_addr
  );
endinterface

// File: rtl/instruction_fetcher.sv
// RV32IC fetch unit: one request at a time, bimodal branch prediction, static JAL/C.J
// following, and a single registered instruction slot presented to the decoder.
module instruction_fetcher #(
  parameter int          BHT_BITS = 6,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  instruction_fetcher_if.master        bus,
  input  logic                         rob_clear,
  input  logic [31:0]                  rob_new_pc,
  input  logic                         br_update_valid,
  input  logic [31:0]                  br_update_pc,
  input  logic                         br_update_taken
);

  localparam int BHT_SIZE = 2 ** BHT_BITS;

  typedef enum logic [1:0] {
    ST_FETCH     = 2'd0,
    ST_PRESENT   = 2'd1,
    ST_WAIT_JALR = 2'd2,
    ST_DISCARD   = 2'd3
  } state_e;

  function automatic logic [31:0] imm_j(input logic [31:0] w);
    return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] w);
    return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_cj(input logic [31:0] w);
    return {{21{w[12]}}, w[8], w[10:9], w[6], w[7], w[2], w[11], w[5:3], 1'b0};
  endfunction

  function automatic logic [31:0] imm_cb(input logic [31:0] w);
    return {{24{w[12]}}, w[6:5], w[2], w[11:10], w[4:3], 1'b0};
  endfunction

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (cnt == 2'b11) ? cnt : cnt + 2'b01;
    end else begin
      res = (cnt == 2'b00) ? cnt : cnt - 2'b01;
    end
    return res;
  endfunction

  state_e      state_r;
  logic [31:0] fetch_pc_r;
  logic        req_valid_r;
  logic [31:0] req_addr_r;
  logic        ins_ready_r;
  logic [31:0] ins_r;
  logic [31:0] pc_out_r;
  logic [31:0] nxt_r;
  logic        jalr_r;
  logic [1:0]  bht_r [0:BHT_SIZE-1];

  logic [31:0]         word_s;
  logic                is_comp_s;
  logic                is_cq1_s;
  logic [2:0]          funct3_s;
  logic [31:0]         seq_pc_s;
  logic [31:0]         target_s;
  logic                taken_s;
  logic                jalr_s;
  logic [31:0]         nxt_s;
  logic [31:0]         ins_s;
  logic [BHT_BITS-1:0] lookup_idx_s;
  logic [BHT_BITS-1:0] upd_idx_s;
  logic                redirect_s;
  logic [31:0]         redirect_pc_s;
  logic                outstanding_s;
  logic                unused_s;

  assign unused_s = ^{br_update_pc[31:BHT_BITS+1], br_update_pc[0]};

  // Decode the returned word against the address it was fetched from.
  always_comb begin
    word_s       = bus.mem_resp_data;
    is_comp_s    = (word_s[1:0] != 2'b11);
    is_cq1_s     = (word_s[1:0] == 2'b01);
    funct3_s     = word_s[15:13];
    seq_pc_s     = req_addr_r + (is_comp_s ? 32'd2 : 32'd4);
    lookup_idx_s = req_addr_r[BHT_BITS:1];
    target_s     = seq_pc_s;
    taken_s      = 1'b0;
    jalr_s       = 1'b0;
    if (word_s[6:0] == 7'b1101111) begin
      target_s = req_addr_r + imm_j(word_s);
      taken_s  = 1'b1;
    end else if (is_cq1_s && (funct3_s == 3'b101 || funct3_s == 3'b001)) begin
      target_s = req_addr_r + imm_cj(word_s);
      taken_s  = 1'b1;
    end else if (word_s[6:0] == 7'b1100011) begin
      target_s = req_addr_r + imm_b(word_s);
      taken_s  = bht_r[lookup_idx_s][1];
    end else if (is_cq1_s && funct3_s[2:1] == 2'b11) begin
      target_s = req_addr_r + imm_cb(word_s);
      taken_s  = bht_r[lookup_idx_s][1];
    end else if ((word_s[6:0] == 7'b1100111) ||
                 (word_s[1:0] == 2'b10 && funct3_s == 3'b100 &&
                  word_s[6:2] == 5'd0 && word_s[11:7] != 5'd0)) begin
      jalr_s = 1'b1;
    end else begin
      taken_s = 1'b0;
    end
    nxt_s = taken_s ? target_s : seq_pc_s;
    ins_s = is_comp_s ? {16'h0000, word_s[15:0]} : word_s;
  end

  // A request still in flight must be drained before the redirect target can be fetched.
  always_comb begin
    redirect_s    = rob_clear || bus.dec_clear;
    redirect_pc_s = rob_clear ? rob_new_pc : bus.dec_new_addr;
    upd_idx_s     = br_update_pc[BHT_BITS:1];
    outstanding_s = (state_r == ST_FETCH || state_r == ST_DISCARD) &&
                    req_valid_r && !bus.mem_resp_valid;
  end

  // Fetch control FSM with registered memory and decoder outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r     <= ST_FETCH;
      fetch_pc_r  <= RESET_PC;
      req_valid_r <= 1'b0;
      req_addr_r  <= RESET_PC;
      ins_ready_r <= 1'b0;
      ins_r       <= 32'h0;
      pc_out_r    <= 32'h0;
      nxt_r       <= 32'h0;
      jalr_r      <= 1'b0;
    end else if (rdy_in) begin
      if (redirect_s) begin
        fetch_pc_r  <= redirect_pc_s;
        ins_ready_r <= 1'b0;
        if (outstanding_s) begin
          state_r <= ST_DISCARD;
        end else begin
          state_r     <= ST_FETCH;
          req_valid_r <= 1'b1;
          req_addr_r  <= redirect_pc_s;
        end
      end else begin
        case (state_r)
          ST_FETCH: begin
            if (!req_valid_r) begin
              req_valid_r <= 1'b1;
              req_addr_r  <= fetch_pc_r;
            end else if (bus.mem_resp_valid) begin
              req_valid_r <= 1'b0;
              ins_ready_r <= 1'b1;
              ins_r       <= ins_s;
              pc_out_r    <= {req_addr_r[31:1], taken_s};
              nxt_r       <= nxt_s;
              jalr_r      <= jalr_s;
              state_r     <= ST_PRESENT;
            end
          end
          ST_PRESENT: begin
            if (!bus.dec_stall) begin
              ins_ready_r <= 1'b0;
              if (jalr_r) begin
                state_r <= ST_WAIT_JALR;
              end else begin
                fetch_pc_r  <= nxt_r;
                req_valid_r <= 1'b1;
                req_addr_r  <= nxt_r;
                state_r     <= ST_FETCH;
              end
            end
          end
          ST_WAIT_JALR: begin
            state_r <= ST_WAIT_JALR;
          end
          ST_DISCARD: begin
            if (bus.mem_resp_valid) begin
              req_valid_r <= 1'b1;
              req_addr_r  <= fetch_pc_r;
              state_r     <= ST_FETCH;
            end
          end
          default: begin
            state_r <= ST_FETCH;
          end
        endcase
      end
    end
  end

  // Bimodal predictor training; same-cycle lookups read the pre-update counter.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bht_r <= '{default: 2'b01};
    end else if (rdy_in && br_update_valid) begin
      bht_r[upd_idx_s] <= sat_update(bht_r[upd_idx_s], br_update_taken);
    end
  end

  assign bus.mem_req_valid      = req_valid_r;
  assign bus.mem_req_addr       = req_addr_r;
  assign bus.dec_ins_ready      = ins_ready_r;
  assign bus.dec_ins            = ins_r;
  assign bus.dec_pc             = pc_out_r;
  assign bus.dec_predict_nxt_pc = nxt_r;

endmodule
